// File: rtl/frame_sequencer.sv
// frame_sequencer: runs one ERASE -> UPDATE -> DRAW frame per accepted 30 Hz tick.
//   Each phase is a level req / done handshake with its engine. A completed-frame
//   counter (0..FRAME_MAX) and a once-per-second pulse feed the debug display.
//   One tick that arrives mid-frame is held as pending. Any further tick in the
//   same frame is dropped.
// Optional feature macro: FRAME_SEQ_OVERRUN_CNT_EN
//   When defined, dropped ticks are counted in overrun_count, which saturates at 255.
//   When undefined, overrun_count is tied to 0.
// Ports:
//   clock, resetn                    clock, async active-low reset
//   frame_tick                       1-cycle 30 Hz pulse
//   enable                           accept new frames (0 = pause after current frame)
//   erase_done/update_done/draw_done engine completion, sampled only in own phase
//   erase_req/update_req/draw_req    phase request levels (one-hot or all 0)
//   busy                             frame in flight
//   frame_done, sec_tick             1-cycle completion / wrap pulses
//   frame_count                      completed frames modulo FRAME_MAX+1
//   overrun_count                    dropped ticks (saturating)
module frame_sequencer #(
  parameter int unsigned FRAME_W   = 5,
  parameter int unsigned FRAME_MAX = 29
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               enable,
  input  logic               erase_done,
  input  logic               update_done,
  input  logic               draw_done,
  output logic               erase_req,
  output logic               update_req,
  output logic               draw_req,
  output logic               busy,
  output logic               frame_done,
  output logic               sec_tick,
  output logic [FRAME_W-1:0] frame_count,
  output logic [7:0]         overrun_count
);

  localparam int unsigned OVR_W = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ERASE  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_DRAW   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic               pending_q, pending_d;
  logic [FRAME_W-1:0] count_q, count_d;
  logic               frame_done_q, frame_done_d;
  logic               sec_tick_q, sec_tick_d;
  logic               erase_req_q, update_req_q, draw_req_q, busy_q;

  // Next-state, pending-tick and frame-counter logic
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    count_d      = count_q;
    frame_done_d = 1'b0;
    sec_tick_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && (frame_tick || pending_q)) begin
          state_d   = ST_ERASE;
          pending_d = 1'b0;
        end else if (!enable) begin
          pending_d = 1'b0;
        end
      end
      ST_ERASE: begin
        if (erase_done) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (update_done) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (draw_done) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          if (count_q == FRAME_W'(FRAME_MAX)) begin
            count_d    = '0;
            sec_tick_d = 1'b1;
          end else begin
            count_d = count_q + FRAME_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tick during a frame is remembered once. This also covers a tick on the draw_done edge.
    if ((state_q != ST_IDLE) && frame_tick && !pending_q) pending_d = 1'b1;
  end

  // State register plus registered outputs decoded from the next state
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      count_q      <= '0;
      frame_done_q <= 1'b0;
      sec_tick_q   <= 1'b0;
      erase_req_q  <= 1'b0;
      update_req_q <= 1'b0;
      draw_req_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      count_q      <= count_d;
      frame_done_q <= frame_done_d;
      sec_tick_q   <= sec_tick_d;
      erase_req_q  <= (state_d == ST_ERASE);
      update_req_q <= (state_d == ST_UPDATE);
      draw_req_q   <= (state_d == ST_DRAW);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

`ifdef FRAME_SEQ_OVERRUN_CNT_EN
  logic             overrun_hit_c;
  logic [OVR_W-1:0] overrun_q;

  // Second and later ticks within one frame are dropped
  assign overrun_hit_c = (state_q != ST_IDLE) && frame_tick && pending_q;

  // Saturating overrun counter, cleared only by reset
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overrun_q <= '0;
    end else if (overrun_hit_c && (overrun_q != {OVR_W{1'b1}})) begin
      overrun_q <= overrun_q + OVR_W'(1);
    end
  end

  assign overrun_count = overrun_q;
`else
  assign overrun_count = OVR_W'(0);
`endif

  assign erase_req   = erase_req_q;
  assign update_req  = update_req_q;
  assign draw_req    = draw_req_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign sec_tick    = sec_tick_q;
  assign frame_count = count_q;

endmodule
